cubehash_msg_feeder: RTL

Upstream feeder for the CubeHash top. It accepts a message as a byte stream and applies CubeHash padding (0x80, then zeros to a 32-byte block). It packs each 256-bit block into sixteen 16-bit words and drives the core's init/load/idata port, waiting for the core's ack before sending the next block. Hash readout (fetch/odata) is out of scope; the block only reports when the final padded block has been absorbed.

---
 rtl/cubehash_msg_feeder.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/cubehash_msg_feeder.sv
`default_nettype none
// ============================================================================
// Module   : cubehash_msg_feeder
// Brief    : Byte-stream front end for a CubeHash core. Buffers 32-byte
//            blocks, applies 0x80/zero padding and streams each block as
//            sixteen 16-bit words, waiting for the core ack between blocks.
// Revision : 1.0 - initial release
// ============================================================================
module cubehash_msg_feeder #(
  parameter int WAIT_LIMIT = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic        hc_init,
  output logic        hc_load,
  output logic [15:0] hc_idata,
  input  logic        hc_ack,
  output logic        busy,
  output logic        msg_done,
  output logic        err
);

  localparam int WCW = $clog2(WAIT_LIMIT + 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INIT     = 3'd1,
    ST_FILL     = 3'd2,
    ST_PAD      = 3'd3,
    ST_SEND     = 3'd4,
    ST_WAIT_ACK = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [5:0]      byte_cnt_q, byte_cnt_d;
  logic [3:0]      word_cnt_q, word_cnt_d;
  logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
  logic            final_q, final_d;
  logic            pad_pending_q, pad_pending_d;
  logic [7:0]      blk_q [32];
  logic [7:0]      blk_d [32];
  logic            err_q, err_d;
  logic            s_ready_q, s_ready_d;
  logic            hc_init_q, hc_init_d;
  logic            hc_load_q, hc_load_d;
  logic [15:0]     hc_idata_q, hc_idata_d;
  logic            busy_q, busy_d;
  logic            msg_done_q, msg_done_d;

  // Next-state, buffer update and next registered-output computation
  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    word_cnt_d    = word_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    final_d       = final_q;
    pad_pending_d = pad_pending_q;
    blk_d         = blk_q;
    err_d         = err_q;
    msg_done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_INIT;
      end
      ST_INIT: begin
        byte_cnt_d    = 6'd0;
        final_d       = 1'b0;
        pad_pending_d = 1'b0;
        state_d       = ST_FILL;
      end
      ST_FILL: begin
        if (s_valid) begin
          blk_d[byte_cnt_q[4:0]] = s_data;
          byte_cnt_d             = byte_cnt_q + 6'd1;
          if (byte_cnt_q == 6'd31) begin
            // Block full; a final byte here still owes a pure padding block
            final_d       = 1'b0;
            pad_pending_d = s_last;
            word_cnt_d    = 4'd0;
            state_d       = ST_SEND;
          end else if (s_last) begin
            state_d = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        for (int i = 0; i < 32; i++) begin
          if (6'(i) == byte_cnt_q)     blk_d[i] = 8'h80;
          else if (6'(i) > byte_cnt_q) blk_d[i] = 8'h00;
        end
        final_d    = 1'b1;
        word_cnt_d = 4'd0;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        if (word_cnt_q == 4'd15) begin
          wait_cnt_d = '0;
          state_d    = ST_WAIT_ACK;
        end else begin
          word_cnt_d = word_cnt_q + 4'd1;
        end
      end
      ST_WAIT_ACK: begin
        if (hc_ack) begin
          if (final_q) begin
            msg_done_d = 1'b1;
            state_d    = ST_IDLE;
          end else if (pad_pending_q) begin
            pad_pending_d = 1'b0;
            for (int i = 0; i < 32; i++) blk_d[i] = 8'h00;
            byte_cnt_d = 6'd0;
            state_d    = ST_PAD;
          end else begin
            byte_cnt_d = 6'd0;
            state_d    = ST_FILL;
          end
        end else if (wait_cnt_q >= WCW'(WAIT_LIMIT - 1)) begin
          // Counter is about to reach the limit: give up on this message
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it
    s_ready_d  = (state_d == ST_FILL);
    hc_init_d  = (state_d == ST_INIT);
    hc_load_d  = (state_d == ST_SEND);
    busy_d     = (state_d != ST_IDLE);
    hc_idata_d = 16'h0000;
    if (state_d == ST_SEND)
      hc_idata_d = {blk_d[{word_cnt_d, 1'b0}], blk_d[{word_cnt_d, 1'b1}]};
  end

  // State, counters, buffer and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      byte_cnt_q    <= 6'd0;
      word_cnt_q    <= 4'd0;
      wait_cnt_q    <= '0;
      final_q       <= 1'b0;
      pad_pending_q <= 1'b0;
      blk_q         <= '{default: 8'h00};
      err_q         <= 1'b0;
      s_ready_q     <= 1'b0;
      hc_init_q     <= 1'b0;
      hc_load_q     <= 1'b0;
      hc_idata_q    <= 16'h0000;
      busy_q        <= 1'b0;
      msg_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      word_cnt_q    <= word_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      final_q       <= final_d;
      pad_pending_q <= pad_pending_d;
      blk_q         <= blk_d;
      err_q         <= err_d;
      s_ready_q     <= s_ready_d;
      hc_init_q     <= hc_init_d;
      hc_load_q     <= hc_load_d;
      hc_idata_q    <= hc_idata_d;
      busy_q        <= busy_d;
      msg_done_q    <= msg_done_d;
    end
  end

  assign s_ready  = s_ready_q;
  assign hc_init  = hc_init_q;
  assign hc_load  = hc_load_q;
  assign hc_idata = hc_idata_q;
  assign busy     = busy_q;
  assign msg_done = msg_done_q;
  assign err      = err_q;

endmodule
`default_nettype wire
